dmem_arbiter: RTL and testbench

Shares the single-port 256x8 data memory between the CPU datapath and the debug/loader port, and adds a hardware memory-clear engine. Sits between both requesters and the data memory's address, write-data, write-enable and read-data pins. Arbitrates one access per clock with a two-way round-robin, and stalls the loser with a req/gnt handshake. On command, the clear engine walks every address and writes zero, locking out both requesters.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_arbiter_rr_arb2.sv | 42 ++++
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter slice.
//   state_t   - arbiter FSM states (ARB: normal arbitration, CLEAR: memory wipe)
//   PORT_*    - bit positions of each requester in the req/gnt vectors
//   DEF_AW/DW - default address and data widths (256 x 8 memory)
package dmem_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a zero-latency combinational grant.
//   clk, rst  - clock and asynchronous active-high reset
//   req[1:0]  - requests, indexed by PORT_CPU / PORT_DBG
//   en        - arbitration enable; when low no grant is issued and the
//               round-robin history is frozen
//   gnt[1:0]  - one-hot (or zero) grant
// The history bit only moves on a contended grant, so an uncontended access
// never changes who wins the next collision.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // 1 = debug port won the most recent contention, so the CPU wins the next.
  logic last_dbg_reg;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt[PORT_CPU] = last_dbg_reg;
        gnt[PORT_DBG] = ~last_dbg_reg;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_dbg_reg <= 1'b1;
    end else if (en && req == 2'b11) begin
      last_dbg_reg <= gnt[PORT_DBG];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the CPU and the
// debug/loader port, and provides a hardware clear engine.
//   clk, rst                    - clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata       - CPU access request (held until cpu_gnt)
//   cpu_gnt, cpu_rdata          - combinational grant and read data
//   dbg_*                       - identical requester port for debug/loader
//   clr_start                   - pulse: wipe the whole memory to zero
//   clr_busy, clr_done          - clear in progress / one-cycle completion
//   mem_addr/wdata/we, mem_rdata - memory pins (write on rising clk,
//                                  combinational read)
// During a clear both requesters are locked out and every address is written
// with zero, one per cycle, from 0 up to 2^AW-1.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic [DW-1:0] dbg_rdata,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  // Counter carries one spare bit; the clear ends on the last address, so
  // the top bit never actually gets set.
  localparam logic [AW:0] CNT_LAST = {1'b0, {AW{1'b1}}};
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

  state_t      state_reg;
  logic [AW:0] count_reg;
  logic        done_reg;

  logic        arb_en;
  logic [1:0]  req;
  logic [1:0]  gnt;

  // Gating with rst keeps every combinational output at zero during reset.
  assign arb_en        = (state_reg == ARB) && !rst;
  assign req[PORT_CPU] = cpu_req;
  assign req[PORT_DBG] = dbg_req;

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign cpu_gnt   = gnt[PORT_CPU];
  assign dbg_gnt   = gnt[PORT_DBG];
  assign cpu_rdata = cpu_gnt ? mem_rdata : '0;
  assign dbg_rdata = dbg_gnt ? mem_rdata : '0;
  assign clr_busy  = (state_reg == CLEAR);
  assign clr_done  = done_reg;

  // Memory pin mux: clear engine, then whichever port holds the grant.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (state_reg == CLEAR) begin
      mem_addr  = count_reg[AW-1:0];
      mem_we    = 1'b1;
    end else if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end else if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we;
    end
  end

  // Clear FSM. clr_start is only honoured in ARB, so a re-pulse mid-clear
  // neither restarts nor extends the wipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ARB;
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ARB: begin
          if (clr_start) begin
            state_reg <= CLEAR;
            count_reg <= '0;
          end
        end
        CLEAR: begin
          if (count_reg == CNT_LAST) begin
            state_reg <= ARB;
            count_reg <= '0;
            done_reg  <= 1'b1;
          end else begin
            count_reg <= count_reg + CNT_ONE;
          end
        end
        default: state_reg <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized, handshake-respecting
// traffic, all checked every cycle against a behavioural model of the
// arbiter (reference memory image, "who wins the next collision" flag and a
// clear-progress index).
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0;
  logic       cpu_gnt;
  logic [7:0] cpu_rdata;
  logic       dbg_req = 1'b0, dbg_we = 1'b0;
  logic [7:0] dbg_addr = '0, dbg_wdata = '0;
  logic       dbg_gnt;
  logic [7:0] dbg_rdata;
  logic       clr_start = 1'b0;
  logic       clr_busy, clr_done;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;

  always #5 clk = ~clk;

  // Behavioural single-port memory seen by the DUT (written by the stimulus
  // process on each rising edge, see step()).
  logic [7:0] tb_mem [256];
  assign mem_rdata = tb_mem[mem_addr];

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] ref_mem [256];
  bit  clearing     = 0;
  int  clear_idx    = 0;
  bit  done_pending = 0;
  bit  cpu_first    = 1;   // CPU wins the next collision
  bit  g_cpu, g_dbg;       // model grants of the last step
  int  obs_busy, obs_done, cyc;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle. Inputs are set by the caller at the falling edge;
  // outputs are checked shortly after, then the model advances.
  task automatic step();
    bit         e_cpu, e_dbg, e_we;
    logic [7:0] e_addr, e_wdata;
    logic       s_we;
    logic [7:0] s_addr, s_wdata;
    #1;
    cyc++;
    obs_busy += int'(clr_busy);
    obs_done += int'(clr_done);
    s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    if (rst) begin
      check("rst_ctrl", int'({cpu_gnt, dbg_gnt, mem_we, clr_busy, clr_done}), 0);
      check("rst_mem_addr", int'(mem_addr), 0);
      check("rst_rdata", int'({cpu_rdata, dbg_rdata}), 0);
      clearing = 0; clear_idx = 0; done_pending = 0; cpu_first = 1;
      g_cpu = 0; g_dbg = 0;
    end else begin
      check("clr_done", int'(clr_done), int'(done_pending));
      check("clr_busy", int'(clr_busy), int'(clearing));
      e_cpu = 0; e_dbg = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      if (clearing) begin
        e_we = 1; e_addr = 8'(clear_idx);
      end else begin
        if (cpu_req && dbg_req) begin
          e_cpu = cpu_first; e_dbg = !cpu_first;
        end else begin
          e_cpu = cpu_req; e_dbg = dbg_req;
        end
        if (e_cpu) begin
          e_we = cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata;
        end else if (e_dbg) begin
          e_we = dbg_we; e_addr = dbg_addr; e_wdata = dbg_wdata;
        end
      end
      check("cpu_gnt", int'(cpu_gnt), int'(e_cpu));
      check("dbg_gnt", int'(dbg_gnt), int'(e_dbg));
      check("mem_we", int'(mem_we), int'(e_we));
      check("mem_addr", int'(mem_addr), int'(e_addr));
      check("mem_wdata", int'(mem_wdata), int'(e_wdata));
      check("cpu_rdata", int'(cpu_rdata), e_cpu ? int'(ref_mem[e_addr]) : 0);
      check("dbg_rdata", int'(dbg_rdata), e_dbg ? int'(ref_mem[e_addr]) : 0);
      if (e_cpu || e_dbg)
        $display("cyc %0d: %s %s addr=%02h data=%02h", cyc, e_cpu ? "cpu" : "dbg",
                 e_we ? "wr" : "rd", e_addr, e_we ? e_wdata : ref_mem[e_addr]);
      // advance the model
      done_pending = 0;
      if (clearing) begin
        ref_mem[clear_idx] = 8'h00;
        clear_idx++;
        if (clear_idx == 256) begin
          clearing = 0; done_pending = 1;
        end
      end else begin
        if (e_we) ref_mem[e_addr] = e_wdata;
        if (cpu_req && dbg_req) cpu_first = e_dbg;
        if (clr_start) begin
          clearing = 1; clear_idx = 0;
        end
      end
      g_cpu = e_cpu; g_dbg = e_dbg;
    end
    @(posedge clk);
    if (s_we) tb_mem[s_addr] = s_wdata;
    @(negedge clk);
  endtask

  // Present one access on a port and hold it until granted (bounded).
  task automatic access(input bit on_dbg, input bit we, input logic [7:0] addr,
                        input logic [7:0] data, output int cycles);
    bit got;
    got = 0; cycles = 0;
    if (on_dbg) begin
      dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = data;
    end else begin
      cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    end
    while (!got && cycles < 8) begin
      step();
      cycles++;
      got = on_dbg ? g_dbg : g_cpu;
    end
    if (!got) check("access_timeout", 0, 1);
    if (on_dbg) dbg_req = 0; else cpu_req = 0;
  endtask

  initial begin
    int n, gc, gd;
    bit c_pend, d_pend;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    @(negedge clk);
    step();
    step();

    // Basic write then read-back on the CPU port
    rst = 0;
    access(0, 1, 8'h10, 8'hA5, n);
    check("t1_wr_latency", n, 1);
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    #1;
    check("t1_rdata", int'(cpu_rdata), 'hA5);
    check("t1_dbg_gnt", int'(dbg_gnt), 0);
    step();
    cpu_req = 0;

    // First contention: CPU wins, debug follows next cycle
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h21; dbg_wdata = 8'h3C;
    #1;
    check("c1_cpu_gnt", int'(cpu_gnt), 1);
    check("c1_dbg_gnt", int'(dbg_gnt), 0);
    step();
    cpu_req = 0;
    #1;
    check("c2_dbg_gnt", int'(dbg_gnt), 1);
    check("c2_mem_we", int'(mem_we), 1);
    check("c2_mem_addr", int'(mem_addr), 'h21);
    step();
    dbg_req = 0;

    // Sustained contention: strict alternation, no starvation
    gc = 0; gd = 0;
    cpu_req = 1; dbg_req = 1; cpu_we = 0; dbg_we = 0;
    for (int i = 0; i < 6; i++) begin
      cpu_addr = 8'(i); dbg_addr = 8'(i + 8);
      step();
      gc += int'(g_cpu); gd += int'(g_dbg);
    end
    cpu_req = 0; dbg_req = 0;
    check("alt_cpu_count", gc, 3);
    check("alt_dbg_count", gd, 3);

    // Full clear with a re-pulse in the middle and both ports requesting
    access(0, 1, 8'h00, 8'hFF, n);
    access(1, 1, 8'h7F, 8'hFF, n);
    access(0, 1, 8'hFF, 8'hFF, n);
    obs_busy = 0; obs_done = 0;
    clr_start = 1;
    step();
    clr_start = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h00;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h7F;
    for (int i = 0; i < 256; i++) begin
      clr_start = (i == 100);
      step();
    end
    clr_start = 0;
    for (int k = 0; k < 4 && (cpu_req || dbg_req); k++) begin
      step();
      if (g_cpu) cpu_req = 0;
      if (g_dbg) dbg_req = 0;
    end
    check("clr_drain", int'(cpu_req | dbg_req), 0);
    cpu_req = 0; dbg_req = 0;
    check("clr_busy_cycles", obs_busy, 256);
    check("clr_done_pulses", obs_done, 1);
    access(0, 0, 8'hFF, 8'h00, n);

    // Reset in the middle of a clear
    access(0, 1, 8'h31, 8'hEE, n);
    access(0, 1, 8'h32, 8'hEE, n);
    access(1, 1, 8'h40, 8'hEE, n);
    clr_start = 1;
    step();
    clr_start = 0;
    for (int i = 0; i < 50; i++) step();
    rst = 1;
    #1;
    check("rst_mid_busy", int'(clr_busy), 0);
    step();
    rst = 0;
    access(0, 0, 8'h32, 8'h00, n);
    check("post_rst_latency", n, 1);
    access(0, 0, 8'h31, 8'h00, n);
    access(1, 0, 8'h40, 8'h00, n);

    // Randomized traffic following the req/gnt handshake
    c_pend = 0; d_pend = 0;
    for (int i = 0; i < 900; i++) begin
      if (!c_pend && $urandom_range(0, 9) < 7) begin
        c_pend = 1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
        cpu_wdata = 8'($urandom);
      end else if (c_pend && $urandom_range(0, 19) == 0) begin
        c_pend = 0;
      end
      if (!d_pend && $urandom_range(0, 9) < 7) begin
        d_pend = 1; dbg_we = 1'($urandom_range(0, 1));
        dbg_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
        dbg_wdata = 8'($urandom);
      end else if (d_pend && $urandom_range(0, 19) == 0) begin
        d_pend = 0;
      end
      cpu_req = c_pend; dbg_req = d_pend;
      clr_start = ($urandom_range(0, 299) == 0);
      step();
      if (g_cpu) c_pend = 0;
      if (g_dbg) d_pend = 0;
    end
    cpu_req = 0; dbg_req = 0; clr_start = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
